// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// -----------------
// Latency-aware register scoreboard for the ID stage of the pipelined MIPS
// core. Every architectural register (except the hard-wired zero register)
// owns a small down-counter holding the number of cycles until its pending
// result becomes forwardable. The ID instruction is held (stall) while one
// of its sources is still in flight (RAW) or while an older write to its
// destination would land at or after its own result (WAW).
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous, active-high reset
//   issue_valid  an instruction is present in ID
//   flush        kill the ID instruction this cycle
//   src_rs       rs address,  src_rs_used: instruction reads rs
//   src_rt       rt address,  src_rt_used: instruction reads rt
//   dst_rd       destination, dst_wen: instruction writes dst_rd
//   dst_lat      result latency (0 treated as 1, clamped to MAX_LAT)
//   stall        ID instruction must wait (combinational)
//   issue_ok     ID instruction issues this cycle (combinational)
//   pending      bit i set while register i has a result in flight
//   busy         any register pending
module hazard_scoreboard #(
  parameter int NREGS   = 32,
  parameter int AW      = 5,
  parameter int MAX_LAT = 4,
  parameter int CW      = $clog2(MAX_LAT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic             flush,
  input  logic [AW-1:0]    src_rs,
  input  logic             src_rs_used,
  input  logic [AW-1:0]    src_rt,
  input  logic             src_rt_used,
  input  logic [AW-1:0]    dst_rd,
  input  logic             dst_wen,
  input  logic [CW-1:0]    dst_lat,
  output logic             stall,
  output logic             issue_ok,
  output logic [NREGS-1:0] pending,
  output logic             busy
);

  // Register 0 never gets a counter, so the array starts at index 1.
  logic [CW-1:0] cnt [1:NREGS-1];

  // Full address-space view of the counters: register 0 and any address
  // beyond NREGS-1 read as zero, so lookups need no special casing.
  logic [CW-1:0] cnt_view [2**AW];

  logic [CW-1:0] lat_eff;
  logic          raw_rs;
  logic          raw_rt;
  logic          waw;

  // Effective latency: a zero latency still takes one cycle, and anything
  // longer than the deepest unit is treated as the deepest unit.
  always_comb begin
    lat_eff = dst_lat;
    if (dst_lat == '0) begin
      lat_eff = CW'(1);
    end else if (dst_lat > CW'(MAX_LAT)) begin
      lat_eff = CW'(MAX_LAT);
    end
  end

  // Build the zero-padded counter view used by the hazard lookups.
  always_comb begin
    for (int i = 0; i < 2**AW; i++) begin
      cnt_view[i] = '0;
    end
    for (int i = 1; i < NREGS; i++) begin
      cnt_view[i] = cnt[i];
    end
  end

  // Hazard detection against the counters as they stand this cycle, before
  // any load at the coming edge. A WAW hazard exists when the older result
  // would still be outstanding once the new result lands, which would let
  // the stale value overwrite the newer one.
  always_comb begin
    raw_rs   = src_rs_used && (src_rs != '0) && (cnt_view[src_rs] != '0);
    raw_rt   = src_rt_used && (src_rt != '0) && (cnt_view[src_rt] != '0);
    waw      = dst_wen && (dst_rd != '0) && (cnt_view[dst_rd] >= lat_eff);
    stall    = issue_valid && !flush && (raw_rs || raw_rt || waw);
    issue_ok = issue_valid && !flush && !stall;
  end

  // Per-register countdown. An issuing writer loads L-1 so the counter hits
  // zero exactly in the cycle its consumer may issue; the load takes
  // priority over the decrement, and an idle counter saturates at zero.
  // Flushed or stalled instructions never load, but running counters keep
  // draining because older instructions are unaffected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NREGS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (issue_ok && dst_wen && (dst_rd == AW'(i))) begin
          cnt[i] <= lat_eff - CW'(1);
        end else if (cnt[i] != '0) begin
          cnt[i] <= cnt[i] - CW'(1);
        end
      end
    end
  end

  // Status outputs are pure functions of the counter registers, so they
  // change only after a clock edge (or immediately on reset).
  always_comb begin
    pending = '0;
    for (int i = 1; i < NREGS; i++) begin
      pending[i] = (cnt[i] != '0);
    end
  end

  assign busy = |pending;

endmodule
